rv_imem_fetch: RTL and testbench
================================

RV_IMEM_FETCH -- requirements
Module: rv_imem_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, giving the byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, giving the 32-bit word count; it SHALL be a power of two, at least 4.
REQ-003 SHALL have parameter LATENCY, default 1, giving the accept-to-response cycles; the legal range is 1..4.
REQ-004 SHALL have parameter BUF_DEPTH, default 2, giving the response buffer entries; the legal range is 2..8.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port req_valid_i, input, 1 bit: a fetch request is present.
REQ-008 SHALL have port req_ready_o, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port req_addr_i, input, ADDR_WIDTH bits: the fetch byte address.
REQ-010 SHALL have port flush_i, input, 1 bit: discard all outstanding fetches.
REQ-011 SHALL have port rsp_valid_o, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready_i, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port rsp_instr_o, output, 32 bits: the fetched instruction word.
REQ-014 SHALL have port rsp_addr_o, output, ADDR_WIDTH bits: the byte address of the response.
REQ-015 SHALL have port rsp_err_o, output, 2 bits: 00 ok, 01 misaligned, 10 out of range.
REQ-016 SHALL hold storage in an internal array named imem, DEPTH_WORDS x 32 bits, preloaded by the bench; the block SHALL never write it.

Function
REQ-017 SHALL accept a request in any cycle where req_valid_i=1 and req_ready_o=1.
REQ-018 SHALL index imem with word index req_addr_i[log2(DEPTH_WORDS)+1:2].
REQ-019 SHALL set error 01 when req_addr_i[1:0]!=0, with rsp_instr_o=32'h00000013 (NOP).
REQ-020 SHALL set error 10 when the address is aligned but req_addr_i >= 4*DEPTH_WORDS, with rsp_instr_o=32'h00000013.
REQ-021 SHALL give misalignment priority over out-of-range.
REQ-022 SHALL, for a request accepted in cycle T while the buffer is empty and no earlier fetch is outstanding, assert rsp_valid_o in cycle T+LATENCY with the matching instr/addr/err.
REQ-023 SHALL pipeline reads through a LATENCY-stage valid/data pipeline that accepts one request per cycle with no bubbles.
REQ-024 SHALL write pipeline outputs into a BUF_DEPTH-entry first-word-fall-through buffer; the buffer head drives rsp_*.
REQ-025 SHALL pop the head in a cycle with rsp_valid_o=1 and rsp_ready_i=1.
REQ-026 SHALL drive req_ready_o = !flush_i and (inflight + occupancy < BUF_DEPTH), where inflight counts valid pipeline stages and occupancy counts buffer entries; this credit rule SHALL make buffer overflow impossible.
REQ-027 SHALL count a same-cycle pop as freeing no credit until the next cycle; req_ready_o SHALL be a function of registered counts and flush_i only.
REQ-028 SHALL, when push and pop occur in the same cycle with the buffer full, hold occupancy constant with no data loss.
REQ-029 SHALL deliver responses strictly in acceptance order.
REQ-030 SHALL keep rsp_instr_o, rsp_addr_o and rsp_err_o stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-031 SHALL wrap buffer read and write pointers modulo BUF_DEPTH.
REQ-032 SHALL, on flush_i=1, deassert req_ready_o in that cycle.
REQ-033 SHALL, on flush_i=1 in cycle T, clear all pipeline valids and the buffer; rsp_valid_o=0 from T+1.
REQ-034 SHALL ignore any pop handshake in the flush cycle.
REQ-035 SHALL let requests accepted from T+1 onward behave per REQ-022.

Reset
REQ-036 SHALL, while reset=1 at a clock edge, clear all pipeline valids, buffer pointers and counts.
REQ-037 SHALL, in the cycle after reset, have rsp_valid_o=0 and req_ready_o=1, and SHALL drive rsp_instr_o=0, rsp_addr_o=0, rsp_err_o=00.
REQ-038 SHALL give reset priority over flush_i and all handshakes.
REQ-039 SHALL discard fetches in flight when reset is asserted mid-operation, producing no response for them.
REQ-040 SHALL leave imem contents unaffected by reset.

Verification
REQ-041 SHALL cover: LATENCY=1, imem[5]=32'h00A00093, request addr 0x14 at T with rsp_ready_i=1 -> rsp_valid_o at T+1, instr 0x00A00093, addr 0x14, err 00.
REQ-042 SHALL cover: request addr 0x16 -> err 01, instr 0x00000013; request addr 0x1000 (DEPTH_WORDS=1024) -> err 10, instr 0x00000013.
REQ-043 SHALL cover: LATENCY=3, BUF_DEPTH=2, rsp_ready_i=0, back-to-back requests -> exactly 2 accepted, then req_ready_o=0; releasing rsp_ready_i -> both returned in order, then req_ready_o=1.
REQ-044 SHALL cover: streaming requests 0x0,0x4,0x8,... with rsp_ready_i=1 and LATENCY=2 -> one response per cycle, no gaps, addresses in order.
REQ-045 SHALL cover: flush_i pulse with 2 in flight and 1 buffered -> rsp_valid_o=0 next cycle, none of those 3 ever appears, and the next request returns after LATENCY cycles.
REQ-046 SHALL cover: reset asserted with a full buffer -> next cycle rsp_valid_o=0, req_ready_o=1, rsp_err_o=00.

Source files
------------

// File: rtl/rv_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rv_imem_fetch
// Brief    : Instruction-memory fetch unit with a fixed-latency read pipeline,
//            a credit-protected FWFT response buffer and flush support.
// Revision : 1.0 - initial release
// ============================================================================
module rv_imem_fetch #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int BUF_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  flush_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_instr_o,
    output logic [ADDR_WIDTH-1:0] rsp_addr_o,
    output logic [1:0]            rsp_err_o
);

    localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
    localparam int          c_PW    = 32 + ADDR_WIDTH + 2;
    localparam int          c_PTR_W = $clog2(BUF_DEPTH);
    localparam int          c_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    logic [31:0] imem [DEPTH_WORDS];

    logic [c_IDX_W-1:0] w_idx;
    logic               w_misal;
    logic               w_oor;
    logic [31:0]        w_in_instr;
    logic [1:0]         w_in_err;
    logic [c_PW-1:0]    w_in;
    logic               w_acc;
    logic               w_wr_valid;
    logic [c_PW-1:0]    w_wr_data;
    logic [c_CNT_W-1:0] w_infl;
    logic [c_CNT_W:0]   w_used;
    logic               w_pop;
    logic [c_PW-1:0]    w_head;

    logic [c_PW-1:0]    r_buf [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_occ;

    assign w_idx   = req_addr_i[c_IDX_W+1:2];
    assign w_misal = |req_addr_i[1:0];

    // Any address bit above the word-index field means the aligned address
    // lies past the end of imem.
    if (ADDR_WIDTH > c_IDX_W + 2) begin : g_oor
        assign w_oor = |req_addr_i[ADDR_WIDTH-1:c_IDX_W+2];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end

    always_comb begin
        w_in_err   = 2'b00;
        w_in_instr = imem[w_idx];
        if (w_misal) begin
            w_in_err   = 2'b01;
            w_in_instr = c_NOP;
        end else if (w_oor) begin
            w_in_err   = 2'b10;
            w_in_instr = c_NOP;
        end
    end

    assign w_in  = {w_in_instr, req_addr_i, w_in_err};
    assign w_acc = req_valid_i & req_ready_o;

    // The buffer write itself is the last latency cycle, so only LATENCY-1
    // register stages sit between acceptance and the buffer.
    if (LATENCY > 1) begin : g_pipe
        localparam int c_NS = LATENCY - 1;
        logic [c_NS-1:0] r_pv;
        logic [c_PW-1:0] r_pd [c_NS];

        always_ff @(posedge clk) begin
            if (reset || flush_i) begin
                r_pv <= '0;
            end else begin
                r_pv[0] <= w_acc;
                for (int i = 1; i < c_NS; i++) begin
                    r_pv[i] <= r_pv[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            r_pd[0] <= w_in;
            for (int i = 1; i < c_NS; i++) begin
                r_pd[i] <= r_pd[i-1];
            end
        end

        assign w_wr_valid = r_pv[c_NS-1];
        assign w_wr_data  = r_pd[c_NS-1];
        assign w_infl     = c_CNT_W'($countones(r_pv));
    end else begin : g_nopipe
        assign w_wr_valid = w_acc;
        assign w_wr_data  = w_in;
        assign w_infl     = '0;
    end

    // Credits come only from registered counts, so a pop frees its slot for
    // new requests one cycle later and the buffer can never overflow.
    assign w_used      = {1'b0, w_infl} + {1'b0, r_occ};
    assign req_ready_o = !flush_i && (w_used < (c_CNT_W+1)'(BUF_DEPTH));

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_valid_o = (r_occ != '0);
    assign w_pop       = rsp_valid_o & rsp_ready_i & ~flush_i;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_wr_valid) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            r_occ <= r_occ + c_CNT_W'(w_wr_valid) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_valid) begin
            r_buf[r_wptr] <= w_wr_data;
        end
    end

    assign w_head      = r_buf[r_rptr];
    assign rsp_instr_o = rsp_valid_o ? w_head[c_PW-1 -: 32]     : '0;
    assign rsp_addr_o  = rsp_valid_o ? w_head[ADDR_WIDTH+1:2]   : '0;
    assign rsp_err_o   = rsp_valid_o ? w_head[1:0]              : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_rv_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_imem_fetch
// Brief    : Directed scoreboard bench for rv_imem_fetch across four configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_imem_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] addr;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv  = 1'b0;
    logic        fl  = 1'b0;
    logic        sr  = 1'b0;
    logic [63:0] ra  = '0;

    logic        rr [4];
    logic        sv [4];
    logic [31:0] si [4];
    logic [63:0] sa [4];
    logic [1:0]  se [4];

    logic [31:0] mem_model [1024];
    exp_t        sb [$];
    int          sel   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rsp = 0;

    always #5 clk = ~clk;

    // Instances: 0 = LAT1/BUF2, 1 = LAT2/BUF4, 2 = LAT3/BUF2, 3 = LAT3/BUF4
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int c_LAT = (g == 0) ? 1 : (g == 1) ? 2 : 3;
        localparam int c_BD  = (g == 1 || g == 3) ? 4 : 2;
        rv_imem_fetch #(
            .ADDR_WIDTH (64),
            .DEPTH_WORDS(1024),
            .LATENCY    (c_LAT),
            .BUF_DEPTH  (c_BD)
        ) u_dut (
            .clk        (clk),
            .reset      (rst),
            .req_valid_i(rv),
            .req_ready_o(rr[g]),
            .req_addr_i (ra),
            .flush_i    (fl),
            .rsp_valid_o(sv[g]),
            .rsp_ready_i(sr),
            .rsp_instr_o(si[g]),
            .rsp_addr_o (sa[g]),
            .rsp_err_o  (se[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a);
        exp_t e;
        e.addr = a;
        if (a[1:0] != 2'b00) begin
            e.err = 2'b01; e.instr = 32'h0000_0013;
        end else if (a >= 64'd4096) begin
            e.err = 2'b10; e.instr = 32'h0000_0013;
        end else begin
            e.err = 2'b00; e.instr = mem_model[a[11:2]];
        end
        return e;
    endfunction

    // Scoreboard: push on accepted request, pop/compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (sv[sel] && sr) begin
                n_rsp++;
                n_cmp++;
                assert (sb.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_rsp: observed addr %0h expected no response", sa[sel]);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_instr", {32'h0, si[sel]}, {32'h0, e.instr});
                    chk("sb_addr", sa[sel], e.addr);
                    chk("sb_err", {62'h0, se[sel]}, {62'h0, e.err});
                end
            end
            if (rv && rr[sel]) sb.push_back(model(ra));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rv = 1'b0; fl = 1'b0; sr = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Single request on instance 0 with consumer ready; response due next cycle.
    task automatic send0(input logic [63:0] a, input logic [31:0] ei, input logic [1:0] ee);
        rv = 1'b1; ra = a; sr = 1'b1;
        @(negedge clk);
        chk("acc_ready", {63'h0, rr[0]}, 64'h1);
        cyc();
        rv = 1'b0;
        @(negedge clk);
        chk("lat1_valid", {63'h0, sv[0]}, 64'h1);
        chk("lat1_instr", {32'h0, si[0]}, {32'h0, ei});
        chk("lat1_addr", sa[0], a);
        chk("lat1_err", {62'h0, se[0]}, {62'h0, ee});
        cyc();
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;
        for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
        mem_model[5] = 32'h00A0_0093;
        for (int i = 0; i < 1024; i++) begin
            g_dut[0].u_dut.imem[i] = mem_model[i];
            g_dut[1].u_dut.imem[i] = mem_model[i];
            g_dut[2].u_dut.imem[i] = mem_model[i];
            g_dut[3].u_dut.imem[i] = mem_model[i];
        end

        // ---- instance 0: reset state and basic fetch / error codes
        sel = 0;
        cyc(); do_reset();
        @(negedge clk);
        chk("rst_valid", {63'h0, sv[0]}, 64'h0);
        chk("rst_ready", {63'h0, rr[0]}, 64'h1);
        chk("rst_instr", {32'h0, si[0]}, 64'h0);
        chk("rst_addr", sa[0], 64'h0);
        chk("rst_err", {62'h0, se[0]}, 64'h0);
        cyc();
        send0(64'h14, 32'h00A0_0093, 2'b00);
        send0(64'h16, 32'h0000_0013, 2'b01);
        send0(64'h1000, 32'h0000_0013, 2'b10);
        send0(64'h1002, 32'h0000_0013, 2'b01);
        send0(64'h0FFC, mem_model[1023], 2'b00);

        // ---- instance 2 (LAT3/BUF2): credit limit under backpressure
        sel = 2;
        do_reset();
        n = 0;
        for (int k = 0; k < 8; k++) begin
            rv = 1'b1; ra = 64'h100 + 64'(4 * n);
            @(negedge clk);
            if (rr[2]) n++;
            cyc();
        end
        rv = 1'b0;
        chk("credit_accepts", 64'(n), 64'd2);
        @(negedge clk);
        chk("credit_ready_low", {63'h0, rr[2]}, 64'h0);
        chk("credit_head", sa[2], 64'h100);
        r0 = n_rsp;
        cyc(); sr = 1'b1;
        @(negedge clk);
        chk("drain_first", sa[2], 64'h100);
        cyc();
        @(negedge clk);
        chk("drain_second", sa[2], 64'h104);
        cyc();
        @(negedge clk);
        chk("drain_ready", {63'h0, rr[2]}, 64'h1);
        chk("drain_empty", {63'h0, sv[2]}, 64'h0);
        chk("drain_count", 64'(n_rsp - r0), 64'd2);
        cyc();

        // ---- instance 1 (LAT2/BUF4): streaming, one response per cycle
        sel = 1;
        do_reset();
        sr = 1'b1;
        n = 0;
        r0 = n_rsp;
        for (int k = 0; k < 20; k++) begin
            rv = (n < 16); ra = 64'(4 * n);
            @(negedge clk);
            if (k >= 2 && k < 18) chk("stream_nogap", {63'h0, sv[1]}, 64'h1);
            if (rv && rr[1]) n++;
            cyc();
        end
        rv = 1'b0;
        chk("stream_accepts", 64'(n), 64'd16);
        chk("stream_rsps", 64'(n_rsp - r0), 64'd16);

        // ---- instance 3 (LAT3/BUF4): flush with 2 in flight and 1 buffered
        sel = 3;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rv = 1'b1; ra = 64'h200 + 64'(4 * k);
            @(negedge clk);
            chk("fl_accept", {63'h0, rr[3]}, 64'h1);
            cyc();
        end
        rv = 1'b0; fl = 1'b1; sr = 1'b1;
        @(negedge clk);
        chk("fl_ready_low", {63'h0, rr[3]}, 64'h0);
        chk("fl_buffered", sa[3], 64'h200);
        cyc();
        fl = 1'b0; rv = 1'b1; ra = 64'h300;
        @(negedge clk);
        chk("fl_valid_cleared", {63'h0, sv[3]}, 64'h0);
        chk("fl_ready_back", {63'h0, rr[3]}, 64'h1);
        cyc();
        rv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("fl_no_ghost", {63'h0, sv[3]}, 64'h0);
            cyc();
        end
        @(negedge clk);
        chk("fl_new_valid", {63'h0, sv[3]}, 64'h1);
        chk("fl_new_addr", sa[3], 64'h300);
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl_after_idle", {63'h0, sv[3]}, 64'h0);
            cyc();
        end

        // ---- instance 0: hold stable when stalled, then reset with full buffer
        sel = 0;
        do_reset();
        sr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv = 1'b1; ra = 64'h8 + 64'(4 * k);
            @(negedge clk);
            chk("full_accept", {63'h0, rr[0]}, 64'h1);
            cyc();
        end
        rv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_ready_low", {63'h0, rr[0]}, 64'h0);
            chk("hold_valid", {63'h0, sv[0]}, 64'h1);
            chk("hold_addr", sa[0], 64'h8);
            chk("hold_instr", {32'h0, si[0]}, {32'h0, mem_model[2]});
            cyc();
        end
        do_reset();
        @(negedge clk);
        chk("rst_full_valid", {63'h0, sv[0]}, 64'h0);
        chk("rst_full_ready", {63'h0, rr[0]}, 64'h1);
        chk("rst_full_err", {62'h0, se[0]}, 64'h0);
        chk("rst_full_addr", sa[0], 64'h0);
        chk("rst_full_instr", {32'h0, si[0]}, 64'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
